// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request port and a word-wide memory.
// Sub-word stores are performed as read-modify-write; misaligned requests complete with an error.
module load_store_unit #(
  parameter bit ALIGN_CHECK = 1'b1,
  localparam int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            mem_rd_en_o,
  output logic            mem_wr_en_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_data_o,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            mem_ack_i
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      size_q;
  logic            we_q;
  logic            uns_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            accept_c;
  logic            misalign_c;
  logic [XLEN-1:0] acc_addr_c;
  logic [4:0]      lane_sh_c;
  logic [XLEN-1:0] lane_c;
  logic [XLEN-1:0] load_c;
  logic [XLEN-1:0] lane_mask_c;
  logic [XLEN-1:0] merge_c;

  assign accept_c = req_valid_i && (state_q == IDLE);

  // Alignment classification and effective address of an incoming request
  always_comb begin
    misalign_c = 1'b0;
    acc_addr_c = req_addr_i;
    case (req_size_i)
      SZ_BYTE: misalign_c = 1'b0;
      SZ_HALF: begin
        misalign_c = ALIGN_CHECK && req_addr_i[0];
        acc_addr_c = {req_addr_i[XLEN-1:1], 1'b0};
      end
      SZ_WORD: begin
        misalign_c = ALIGN_CHECK && (req_addr_i[1:0] != 2'b00);
        acc_addr_c = {req_addr_i[XLEN-1:2], 2'b00};
      end
      default: misalign_c = 1'b1;
    endcase
  end

  // Little-endian lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_sh_c   = {addr_q[1:0], 3'b000};
    lane_c      = mem_data_i >> lane_sh_c;
    load_c      = lane_c;
    lane_mask_c = '1;
    case (size_q)
      SZ_BYTE: begin
        load_c      = uns_q ? {{(XLEN-8){1'b0}}, lane_c[7:0]}
                            : {{(XLEN-8){lane_c[7]}}, lane_c[7:0]};
        lane_mask_c = XLEN'(8'hFF) << lane_sh_c;
      end
      SZ_HALF: begin
        load_c      = uns_q ? {{(XLEN-16){1'b0}}, lane_c[15:0]}
                            : {{(XLEN-16){lane_c[15]}}, lane_c[15:0]};
        lane_mask_c = XLEN'(16'hFFFF) << lane_sh_c;
      end
      default: begin
        load_c      = lane_c;
        lane_mask_c = '1;
      end
    endcase
    merge_c = (mem_data_i & ~lane_mask_c) | ((wdata_q << lane_sh_c) & lane_mask_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and outputs; memory enables are gated by reset so an aborted write never issues
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
    mem_data_o  = wdata_q;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (misalign_c)                            state_d = RESP;
          else if (req_we_i && req_size_i == SZ_WORD) state_d = WRITE;
          else                                       state_d = READ;
        end
      end
      READ: begin
        mem_rd_en_o = rst_n;
        if (mem_ack_i) state_d = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_wr_en_o = rst_n;
        if (mem_ack_i) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture at acceptance; read data captured on the read acknowledge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept_c) begin
      addr_q  <= acc_addr_c;
      size_q  <= req_size_i;
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      wdata_q <= req_wdata_i;
      rdata_q <= '0;
      err_q   <= misalign_c;
    end else if (state_q == READ && mem_ack_i) begin
      if (we_q) wdata_q <= merge_c;
      else      rdata_q <= load_c;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed spec scenarios with literal expectations, then random
// requests against a byte-level memory/response model with a per-cycle compare process.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_rd_en_o, mem_wr_en_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  load_store_unit #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Driver-owned stimulus controls, read by the compare process
  bit          ack_rand = 1'b0;
  int          cur_stall = 0;
  bit          lit_on = 1'b0, lit_mem_on = 1'b0, lit_err = 1'b0;
  logic [31:0] lit_rdata = '0, lit_mem = '0;
  int          lit_lat = 0, lit_rd = 0, lit_wr = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h8899AABB : 32'(i) * 32'h9E3779B1 + 32'h0000_1234;
  endfunction

  // Reference semantics: take n bytes starting at byte offset off, then extend
  function automatic logic [31:0] m_load(input logic [31:0] word, input int n, input bit uns,
                                         input int off);
    longint v, span;
    span = longint'(1) << (8 * n);
    v    = longint'({32'h0, word});
    v    = (v >> (8 * off)) % span;
    if (!uns && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] word, input int n, input int off,
                                          input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + n) r[8*b +: 8] = wdata[8*(b-off) +: 8];
    return r;
  endfunction

  // Memory: combinational read, write committed at the edge where enable and ack were high
  logic [31:0] mem [16];
  logic        wr_s;
  logic [3:0]  wa;
  logic [31:0] wd;
  assign mem_data_i = mem_rd_en_o ? mem[mem_addr_o[5:2]] : 32'hDEAD_BEEF;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      wr_s = mem_wr_en_o && mem_ack_i;
      wa   = mem_addr_o[5:2];
      wd   = mem_data_o;
      @(posedge clk);
      if (wr_s) mem[wa] = wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process state
  logic [31:0] ref_mem [16];
  int          cyc = 0, acc_cyc = 0;
  bit          pending = 1'b0, prev_rst = 1'b0, prev_hold = 1'b0;
  logic        p_rd, p_wr;
  logic [31:0] p_addr, p_data;
  logic [31:0] e_addr, e_rdata, e_word;
  logic [3:0]  e_idx;
  bit          e_err, e_we;
  int          e_lat, e_rd, e_wr, rd_cyc, wr_cyc, rd_ack, wr_ack;

  initial begin
    int n;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_rd_en", 32'(mem_rd_en_o), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en_o), 32'd0);
        pending = 1'b0; prev_hold = 1'b0; prev_rst = 1'b0;
      end else begin
        if (!prev_rst) begin
          chk("rel_ready", 32'(req_ready_o), 32'd1);
          chk("rel_rsp_valid", 32'(rsp_valid_o), 32'd0);
          chk("rel_rsp_err", 32'(rsp_err_o), 32'd0);
          chk("rel_rdata", rsp_rdata_o, 32'd0);
          chk("rel_mem_addr", mem_addr_o, 32'd0);
          chk("rel_mem_data", mem_data_o, 32'd0);
          prev_rst = 1'b1;
        end
        chk("both_en", 32'(mem_rd_en_o && mem_wr_en_o), 32'd0);
        chk("addr_lsb", 32'(mem_addr_o[1:0]), 32'd0);
        chk("ready", 32'(req_ready_o), 32'(!pending));
        if (prev_hold) begin
          chk("hold_rd_en", 32'(mem_rd_en_o), 32'(p_rd));
          chk("hold_wr_en", 32'(mem_wr_en_o), 32'(p_wr));
          chk("hold_addr", mem_addr_o, p_addr);
          if (p_wr) chk("hold_data", mem_data_o, p_data);
        end
        prev_hold = (mem_rd_en_o || mem_wr_en_o) && !mem_ack_i;
        p_rd = mem_rd_en_o; p_wr = mem_wr_en_o; p_addr = mem_addr_o; p_data = mem_data_o;

        if (pending) begin
          if (mem_rd_en_o || mem_wr_en_o) chk("mem_addr", mem_addr_o, {e_addr[31:2], 2'b00});
          if (mem_rd_en_o) rd_cyc++;
          if (mem_wr_en_o) wr_cyc++;
          if (mem_rd_en_o && mem_ack_i) rd_ack++;
          if (mem_wr_en_o && mem_ack_i) wr_ack++;
        end else begin
          chk("idle_en", 32'(mem_rd_en_o || mem_wr_en_o), 32'd0);
          chk("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
        end

        if (rsp_valid_o && pending) begin
          chk("rsp_err", 32'(rsp_err_o), 32'(e_err));
          chk("rsp_rdata", rsp_rdata_o, e_rdata);
          chk("rsp_en", 32'(mem_rd_en_o || mem_wr_en_o), 32'd0);
          chk("rd_acks", 32'(rd_ack), 32'(e_rd));
          chk("wr_acks", 32'(wr_ack), 32'(e_wr));
          if (e_we && !e_err) ref_mem[e_idx] = e_word;
          chk("mem_word", mem[e_idx], ref_mem[e_idx]);
          if (!ack_rand && cur_stall == 0) chk("latency", 32'(cyc - acc_cyc), 32'(e_lat));
          if (lit_on) begin
            chk("lit_rdata", rsp_rdata_o, lit_rdata);
            chk("lit_err", 32'(rsp_err_o), 32'(lit_err));
            chk("lit_latency", 32'(cyc - acc_cyc), 32'(lit_lat));
            chk("lit_rd_cycles", 32'(rd_cyc), 32'(lit_rd));
            chk("lit_wr_cycles", 32'(wr_cyc), 32'(lit_wr));
            if (lit_mem_on) chk("lit_mem", mem[e_idx], lit_mem);
          end
          pending = 1'b0;
        end else begin
          chk("quiet_rdata", rsp_rdata_o, 32'd0);
          chk("quiet_err", 32'(rsp_err_o), 32'd0);
          if (pending && cyc - acc_cyc > 100) begin
            chk("rsp_timeout", 32'(rsp_valid_o), 32'd1);
            pending = 1'b0;
          end
        end

        if (req_valid_i && req_ready_o) begin
          pending = 1'b1;
          acc_cyc = cyc;
          e_addr  = req_addr_i;
          e_idx   = req_addr_i[5:2];
          e_we    = req_we_i;
          n       = 1 << req_size_i;
          e_err   = (req_size_i == 2'd3) || (req_addr_i % n != 0);
          e_rdata = (e_err || req_we_i) ? 32'd0
                  : m_load(ref_mem[e_idx], n, req_unsigned_i, int'(req_addr_i % 4));
          e_word  = m_store(ref_mem[e_idx], n, int'(req_addr_i % 4), req_wdata_i);
          e_rd    = (!e_err && (!req_we_i || n < 4)) ? 1 : 0;
          e_wr    = (!e_err && req_we_i) ? 1 : 0;
          e_lat   = e_err ? 1 : (req_we_i && n < 4) ? 3 : 2;
          rd_cyc = 0; wr_cyc = 0; rd_ack = 0; wr_ack = 0;
        end
      end
    end
  end

  task automatic set_lit(input logic [31:0] rdata, input bit err, input int lat, input int nrd,
                         input int nwr, input bit mem_on, input logic [31:0] mword);
    lit_on = 1'b1; lit_rdata = rdata; lit_err = err; lit_lat = lat;
    lit_rd = nrd; lit_wr = nwr; lit_mem_on = mem_on; lit_mem = mword;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (ack_rand) mem_ack_i = 1'($urandom_range(0, 1));
  endtask

  // Issue one request while the unit is idle and wait (bounded) for its response
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    cur_stall      = stall;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_valid_i    = 1'b1;
    @(posedge clk); #1;
    req_valid_i    = 1'b0;
    req_we_i       = 1'($urandom());
    req_size_i     = 2'($urandom());
    req_unsigned_i = 1'($urandom());
    req_addr_i     = $urandom();
    req_wdata_i    = $urandom();
    mem_ack_i      = ack_rand ? 1'($urandom_range(0, 1)) : (stall == 0);
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (rsp_valid_o) break;
      @(posedge clk); #1;
      mem_ack_i = ack_rand ? 1'($urandom_range(0, 1)) : (k + 1 >= stall);
    end
    step();
    if (!ack_rand) mem_ack_i = 1'b1;
    lit_on = 1'b0; lit_mem_on = 1'b0; cur_stall = 0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; mem_ack_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    set_lit(32'hFFFF_FFAA, 1'b0, 2, 1, 0, 1'b0, '0); do_req(1'b0, 2'b00, 1'b0, 32'h11, '0, 0);
    set_lit(32'h0000_8899, 1'b0, 2, 1, 0, 1'b0, '0); do_req(1'b0, 2'b01, 1'b1, 32'h12, '0, 0);
    set_lit(32'h8899_AABB, 1'b0, 5, 4, 0, 1'b0, '0); do_req(1'b0, 2'b10, 1'b0, 32'h10, '0, 3);
    set_lit(32'h0000_0000, 1'b1, 1, 0, 0, 1'b0, '0); do_req(1'b0, 2'b10, 1'b0, 32'h12, '0, 0);
    set_lit(32'h0000_0000, 1'b0, 3, 1, 1, 1'b1, 32'h5599_AABB);
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5655, 0);
    set_lit(32'h0000_5599, 1'b0, 2, 1, 0, 1'b0, '0); do_req(1'b0, 2'b01, 1'b0, 32'h12, '0, 0);
    set_lit(32'h0000_00BB, 1'b0, 2, 1, 0, 1'b0, '0); do_req(1'b0, 2'b00, 1'b1, 32'h10, '0, 0);

    // Word store aborted by reset in its WRITE cycle
    req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h10; req_wdata_i = 32'hCAFE_F00D; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    set_lit(32'h5599_AABB, 1'b0, 2, 1, 0, 1'b0, '0); do_req(1'b0, 2'b10, 1'b0, 32'h10, '0, 0);

    ack_rand = 1'b1;
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) step();
      do_req(1'($urandom()), 2'($urandom()), 1'($urandom()), 32'($urandom_range(0, 63)),
             $urandom(), 0);
    end
    ack_rand = 1'b0;
    mem_ack_i = 1'b1;
    for (int t = 0; t < 100; t++) begin
      do_req(1'($urandom()), 2'($urandom()), 1'($urandom()), 32'($urandom_range(0, 63)),
             $urandom(), 0);
    end
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001: Parameter ALIGN_CHECK, default 1; 1 = misaligned half/word requests return an error; 0 = addr[1:0] ignored for word and addr[0] ignored for half.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  reset, synchronous, active-low.
- REQ-004: req_valid_i  input  1  core request valid.
- REQ-005: req_ready_o  output  1  unit can accept a request.
- REQ-006: req_we_i  input  1  1 = store, 0 = load.
- REQ-007: req_size_i  input  2  00 byte, 01 half, 10 word; 11 is reserved and treated as misaligned.
- REQ-008: req_unsigned_i  input  1  load zero-extends when 1 and sign-extends when 0.
- REQ-009: req_addr_i  input  32  byte address.
- REQ-010: req_wdata_i  input  32  store data, right-justified.
- REQ-011: rsp_valid_o  output  1  one-cycle completion pulse.
- REQ-012: rsp_rdata_o  output  32  load result, valid with rsp_valid_o; 0 for stores and errors.
- REQ-013: rsp_err_o  output  1  misaligned or reserved-size request, valid with rsp_valid_o.
- REQ-014: mem_rd_en_o, mem_wr_en_o  output  1 each  memory read and write enables.
- REQ-015: mem_addr_o  output  32  word-aligned address, bits [1:0] = 00.
- REQ-016: mem_data_o  output  32  memory write word.
- REQ-017: mem_data_i  input  32  memory read word, combinational, valid while mem_rd_en_o is high.
- REQ-018: mem_ack_i  input  1  memory ready; access completes in any cycle where the enable and ack are both high.

Function
- REQ-019: The FSM SHALL have states IDLE, READ, WRITE and RESP.
- REQ-020: req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1, and all request fields are registered at acceptance.
- REQ-021: Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or size 11) when ALIGN_CHECK=1:
  - IDLE goes directly to RESP; rsp_err_o=1, rsp_rdata_o=0.
  - No memory enable is asserted.
- REQ-022: Load: IDLE -> READ; mem_rd_en_o=1.
  - On mem_ack_i, the byte lane addr[1:0] (little-endian) is extracted, extended per req_unsigned_i and registered; next state is RESP.
- REQ-023: Word store: IDLE -> WRITE; mem_wr_en_o=1, mem_data_o=req_wdata_i; on mem_ack_i go to RESP.
- REQ-024: Byte or half store is a read-modify-write: IDLE -> READ -> WRITE -> RESP.
  - The read word is captured on ack.
  - Only the addressed byte or half-word lanes are replaced by the low bits of req_wdata_i.
  - Other lanes are written back unchanged.
- REQ-025: READ and WRITE SHALL hold while mem_ack_i=0; mem_addr_o, mem_data_o and the enable stay stable during the hold.
- REQ-026: RESP SHALL last exactly one cycle with rsp_valid_o=1, then return to IDLE; rsp_rdata_o and rsp_err_o are 0 outside RESP.
- REQ-027: mem_rd_en_o and mem_wr_en_o SHALL never both be 1, and SHALL be 0 in IDLE and RESP.
- REQ-028: Latency with ack always high, counted from the acceptance edge:
  - load: 2 cycles to rsp_valid_o;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - misaligned request: 1 cycle.
- REQ-029: Back-to-back: a new request can be accepted in the cycle after RESP; there is no pipelining and at most one request is outstanding.

Reset
- REQ-030: While rst_n=0 the FSM SHALL go to IDLE on the next edge, and all registered request fields and results SHALL clear to 0.
- REQ-031: mem_rd_en_o and mem_wr_en_o SHALL be forced to 0 combinationally in any cycle where rst_n=0, so a reset during WRITE issues no memory write.
- REQ-032: After reset releases: req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_addr_o=0, mem_data_o=0.

Verification
- REQ-033: Signed byte load. Memory word 0x10 = 0x8899AABB, always-ack memory; LB signed at addr 0x11 -> rsp_valid_o 2 cycles after acceptance, rsp_rdata_o=0xFFFFFFAA, rsp_err_o=0.
- REQ-034: Unsigned half load. Same memory; LHU at addr 0x12 -> rsp_rdata_o=0x00008899; exactly one mem_rd_en_o cycle with mem_addr_o=0x10.
- REQ-035: Byte store. SB at addr 0x13, wdata 0x12345655 -> one read cycle then one write cycle with mem_data_o=0x5599AABB; memory word 0x10 = 0x5599AABB; rsp_valid_o 3 cycles after acceptance.
- REQ-036: Misaligned load. LW at addr 0x12 with ALIGN_CHECK=1 -> rsp_valid_o next cycle, rsp_err_o=1, rsp_rdata_o=0; no memory enable asserted.
- REQ-037: Ack stall. mem_ack_i held 0 for 3 cycles during a LW of 0x10 -> READ held with mem_addr_o=0x10 stable; response arrives 3 cycles later with rdata 0x8899AABB.
- REQ-038: Reset mid-store. rst_n=0 in the WRITE cycle of an SW to 0x10 -> mem_wr_en_o=0, memory word unchanged, no rsp_valid_o; req_ready_o=1 after release.
